occupancy_display: RTL and testbench

// - Downstream of the 3-bit occupancy counter and the entry/exit FSM in the parking-lot design.
// - Consumes the live count and the in/out event strobes.
// - Drives a 7-segment digit, empty/full flags, a blinking FULL lamp, and in/out activity lamps.
// - Tallies entry attempts that arrive while the lot is full.

---
 rtl/occupancy_display.sv | 142 ++++++++++++++
 tb/tb_occupancy_display.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/occupancy_display.sv
// Parking-lot occupancy display: 7-seg digit, empty/full flags, blinking FULL lamp, activity lamps, reject tally.
// Optional OCC_PEAK_EN adds a peak-occupancy output. Outputs lag count by one cycle; no backpressure.
module occupancy_display #(
    parameter int CAPACITY     = 7,
    parameter int BLINK_DIV    = 8,
    parameter int FLASH_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] count,
    input  logic       in_pulse,
    input  logic       out_pulse,
    input  logic       clear_rej,
    output logic [6:0] seg,
    output logic       empty,
    output logic       full,
    output logic       full_led,
    output logic       led_in,
    output logic       led_out,
    output logic [3:0] reject_cnt
`ifdef OCC_PEAK_EN
    ,
    output logic [2:0] peak
`endif
);

    localparam logic [2:0] CAP = 3'(CAPACITY);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam int TW = $clog2(FLASH_CYCLES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [TW-1:0] FLASH_LOAD = TW'(FLASH_CYCLES);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_AVAIL = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [6:0]    seg_nxt;
    logic [BW-1:0] blink_cnt;
    logic [TW-1:0] in_tmr;
    logic [TW-1:0] out_tmr;

    always_comb begin
        state_nxt = S_AVAIL;
        if (count == 3'd0)
            state_nxt = S_EMPTY;
        else if (count >= CAP)
            state_nxt = S_FULL;
    end

    // Active-low segments {g,f,e,d,c,b,a}
    always_comb begin
        seg_nxt = 7'h40;
        case (count)
            3'd0: seg_nxt = 7'h40;
            3'd1: seg_nxt = 7'h79;
            3'd2: seg_nxt = 7'h24;
            3'd3: seg_nxt = 7'h30;
            3'd4: seg_nxt = 7'h19;
            3'd5: seg_nxt = 7'h12;
            3'd6: seg_nxt = 7'h02;
            3'd7: seg_nxt = 7'h78;
            default: seg_nxt = 7'h40;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_EMPTY;
            seg   <= 7'h40;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            state <= state_nxt;
            seg   <= seg_nxt;
            empty <= (state_nxt == S_EMPTY);
            full  <= (state_nxt == S_FULL);
        end
    end

    // Lamp turns on at the edge entering FULL, then toggles every BLINK_DIV cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full_led  <= 1'b0;
            blink_cnt <= '0;
        end else if (state_nxt != S_FULL) begin
            full_led  <= 1'b0;
            blink_cnt <= '0;
        end else if (state != S_FULL) begin
            full_led  <= 1'b1;
            blink_cnt <= '0;
        end else if (blink_cnt == BLINK_LAST) begin
            full_led  <= ~full_led;
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_tmr  <= '0;
            out_tmr <= '0;
        end else begin
            if (in_pulse)
                in_tmr <= FLASH_LOAD;
            else if (in_tmr != '0)
                in_tmr <= in_tmr - TW'(1);
            if (out_pulse)
                out_tmr <= FLASH_LOAD;
            else if (out_tmr != '0)
                out_tmr <= out_tmr - TW'(1);
        end
    end

    assign led_in  = (in_tmr != '0);
    assign led_out = (out_tmr != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            reject_cnt <= 4'd0;
        else if (clear_rej)
            reject_cnt <= 4'd0;
        else if (in_pulse && (count >= CAP) && (reject_cnt != 4'hF))
            reject_cnt <= reject_cnt + 4'd1;
    end

`ifdef OCC_PEAK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            peak <= 3'd0;
        else if (clear_rej)
            peak <= count;
        else if (count > peak)
            peak <= count;
    end
`endif

endmodule

// File: tb/tb_occupancy_display.sv
// Directed self-checking bench for occupancy_display with default parameters.
module tb_occupancy_display;

    logic       clk;
    logic       reset_n;
    logic [2:0] count;
    logic       in_pulse;
    logic       out_pulse;
    logic       clear_rej;
    logic [6:0] seg;
    logic       empty;
    logic       full;
    logic       full_led;
    logic       led_in;
    logic       led_out;
    logic [3:0] reject_cnt;
`ifdef OCC_PEAK_EN
    logic [2:0] peak;
`endif

    int n_checks;
    int n_fail;

    occupancy_display dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .count      (count),
        .in_pulse   (in_pulse),
        .out_pulse  (out_pulse),
        .clear_rej  (clear_rej),
        .seg        (seg),
        .empty      (empty),
        .full       (full),
        .full_led   (full_led),
        .led_in     (led_in),
        .led_out    (led_out),
        .reject_cnt (reject_cnt)
`ifdef OCC_PEAK_EN
        ,
        .peak       (peak)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seg"}, 32'(seg), 32'h40);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_full_led"}, 32'(full_led), 32'd0);
        check({tag, "_led_in"}, 32'(led_in), 32'd0);
        check({tag, "_led_out"}, 32'(led_out), 32'd0);
        check({tag, "_reject"}, 32'(reject_cnt), 32'd0);
`ifdef OCC_PEAK_EN
        check({tag, "_peak"}, 32'(peak), 32'd0);
`endif
    endtask

    logic [6:0] seg_tab [8];
    logic       in_exp  [8];
    logic       out_exp [8];

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
        in_exp  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        out_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        count     = 3'd0;
        in_pulse  = 1'b0;
        out_pulse = 1'b0;
        clear_rej = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        check_reset_outputs("rst");

        // Count sweep: seg and flags follow one edge later
        for (int i = 0; i < 8; i++) begin
            count = 3'(i);
            step();
            check($sformatf("sweep_seg%0d", i), 32'(seg), 32'(seg_tab[i]));
            check($sformatf("sweep_empty%0d", i), 32'(empty), (i == 0) ? 32'd1 : 32'd0);
            check($sformatf("sweep_full%0d", i), 32'(full), (i == 7) ? 32'd1 : 32'd0);
            step();
            step();
            step();
        end
`ifdef OCC_PEAK_EN
        check("peak_after_sweep", 32'(peak), 32'd7);
`endif

        // Blink: restart from a fresh entry into FULL
        count = 3'd0;
        step();
        check("blink_pre_off", 32'(full_led), 32'd0);
        count = 3'd7;
        for (int k = 0; k < 40; k++) begin
            step();
            check($sformatf("blink_k%0d", k), 32'(full_led), ((k / 8) % 2 == 0) ? 32'd1 : 32'd0);
        end
        count = 3'd6;
        step();
        check("blink_leave_led", 32'(full_led), 32'd0);
        check("blink_leave_full", 32'(full), 32'd0);
        check("blink_leave_seg", 32'(seg), 32'h02);

        // Activity lamps: in at j=0 and j=2, out at j=0
        count = 3'd3;
        for (int j = 0; j < 8; j++) begin
            in_pulse  = (j == 0 || j == 2);
            out_pulse = (j == 0);
            step();
            check($sformatf("flash_in%0d", j), 32'(led_in), 32'(in_exp[j]));
            check($sformatf("flash_out%0d", j), 32'(led_out), 32'(out_exp[j]));
        end
        in_pulse  = 1'b0;
        out_pulse = 1'b0;
        check("flash_no_reject", 32'(reject_cnt), 32'd0);

        // Reject tally saturates at 15
        count = 3'd7;
        step();
        for (int i = 0; i < 17; i++) begin
            in_pulse = 1'b1;
            step();
            check($sformatf("rej_%0d", i), 32'(reject_cnt), (i < 15) ? 32'(i + 1) : 32'd15);
        end
        clear_rej = 1'b1;
        step();
        clear_rej = 1'b0;
        check("rej_clear_prio", 32'(reject_cnt), 32'd0);
        step();
        check("rej_after_clear", 32'(reject_cnt), 32'd1);
        count = 3'd3;
        step();
        in_pulse = 1'b0;
        check("rej_not_full", 32'(reject_cnt), 32'd1);
`ifdef OCC_PEAK_EN
        clear_rej = 1'b1;
        step();
        clear_rej = 1'b0;
        check("peak_clear_load", 32'(peak), 32'd3);
        check("peak_clear_rej", 32'(reject_cnt), 32'd0);
`endif

        // Async reset mid-blink and mid-flash
        count = 3'd7;
        step();
        step();
        in_pulse  = 1'b1;
        out_pulse = 1'b1;
        step();
        in_pulse  = 1'b0;
        out_pulse = 1'b0;
        check("pre_rst_led", 32'(full_led), 32'd1);
        check("pre_rst_in", 32'(led_in), 32'd1);
        check("pre_rst_rej_nz", 32'(reject_cnt != 4'd0), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        count = 3'd0;
        step();
        reset_n = 1'b1;
        step();
        check("post_rst_empty", 32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
